// File: rtl/load_store_unit.sv
// Load/store controller that sits between the datapath and DataMemory.
// Handles byte/half/word accesses, sign/zero extension and read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | waiting for req; validates and latches the request
// RD    | word-aligned address presented for read
// WAIT  | memory read data valid; extract load lane or merge store lane
// WR    | single-cycle write strobe to memory
// DONE  | done pulse (err set on rejected requests)
module load_store_unit #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int IO_SEL_BIT     = 29
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic                      we,
    input  logic [1:0]                size,
    input  logic                      signExt,
    input  logic [ADDR_BIT_WIDTH-1:0] addr,
    input  logic [DATA_BIT_WIDTH-1:0] wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DATA_BIT_WIDTH-1:0] rdata,
    output logic                      memWrtEn,
    output logic [ADDR_BIT_WIDTH-1:0] memAddr,
    output logic [DATA_BIT_WIDTH-1:0] memDIn,
    input  logic [DATA_BIT_WIDTH-1:0] memDOut
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t                    state;
    logic                      we_q;
    logic [1:0]                size_q;
    logic                      sext_q;
    logic [ADDR_BIT_WIDTH-1:0] addr_q;
    logic [DATA_BIT_WIDTH-1:0] wdata_q;
    logic                      wrt_en_q;

    logic                      req_err;
    logic [ADDR_BIT_WIDTH-1:0] aligned_in;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [DATA_BIT_WIDTH-1:0] ld_value;
    logic [DATA_BIT_WIDTH-1:0] st_merge;

    assign aligned_in = {addr[ADDR_BIT_WIDTH-1:2], 2'b00};

    assign req_err = (size == SZ_BAD)
                   | ((size == SZ_HALF) & addr[0])
                   | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
                   | ((size != SZ_WORD) & addr[IO_SEL_BIT]);

    always_comb begin
        ld_byte = memDOut[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = memDOut[7:0];
            2'd1: ld_byte = memDOut[15:8];
            2'd2: ld_byte = memDOut[23:16];
            2'd3: ld_byte = memDOut[31:24];
            default: ld_byte = memDOut[7:0];
        endcase
        ld_half = addr_q[1] ? memDOut[31:16] : memDOut[15:0];

        ld_value = memDOut;
        case (size_q)
            SZ_BYTE: ld_value = sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
            SZ_HALF: ld_value = sext_q ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
            default: ld_value = memDOut;
        endcase
    end

    // Sub-word store merge: untouched lanes come from the word just read.
    always_comb begin
        st_merge = memDOut;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0: st_merge[7:0]   = wdata_q[7:0];
                    2'd1: st_merge[15:8]  = wdata_q[7:0];
                    2'd2: st_merge[23:16] = wdata_q[7:0];
                    2'd3: st_merge[31:24] = wdata_q[7:0];
                    default: st_merge = memDOut;
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1])
                    st_merge[31:16] = wdata_q[15:0];
                else
                    st_merge[15:0] = wdata_q[15:0];
            end
            default: st_merge = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wrt_en_q <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            memAddr  <= '0;
            memDIn   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= signExt;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (req_err) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (we && (size == SZ_WORD)) begin
                            state    <= S_WR;
                            memAddr  <= aligned_in;
                            memDIn   <= wdata;
                            wrt_en_q <= 1'b1;
                        end else begin
                            state   <= S_RD;
                            memAddr <= aligned_in;
                        end
                    end
                end
                S_RD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (we_q) begin
                        memDIn   <= st_merge;
                        wrt_en_q <= 1'b1;
                        state    <= S_WR;
                    end else begin
                        rdata <= ld_value;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_WR: begin
                    wrt_en_q <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    wrt_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Gate with reset so a write in flight is suppressed in the reset cycle itself.
    assign memWrtEn = wrt_en_q & ~reset;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural DataMemory (sync read, MMIO ledr/sw).
module tb_load_store_unit;

    localparam logic [31:0] SW_VAL = 32'h0000_0155;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        signExt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        memWrtEn;
    logic [31:0] memAddr;
    logic [31:0] memDIn;
    logic [31:0] memDOut;

    logic [31:0] mem [0:1023];
    logic [31:0] ledr;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(
        .ADDR_BIT_WIDTH(32),
        .DATA_BIT_WIDTH(32),
        .IO_SEL_BIT(29)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .we(we),
        .size(size),
        .signExt(signExt),
        .addr(addr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .rdata(rdata),
        .memWrtEn(memWrtEn),
        .memAddr(memAddr),
        .memDIn(memDIn),
        .memDOut(memDOut)
    );

    always #5 clk = ~clk;

    // Read-before-write synchronous memory; MMIO writes go to ledr, reads return sw.
    always @(posedge clk) begin
        memDOut <= memAddr[29] ? SW_VAL : mem[memAddr[11:2]];
        if (memWrtEn) begin
            if (memAddr[29])
                ledr = memDIn;
            else
                mem[memAddr[11:2]] = memDIn;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int wcnt, output logic [31:0] wd, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; signExt = sx; addr = a; wdata = d;
        lat = 0; wcnt = 0; wd = 32'h0; e = 1'b0;
        do begin
            @(negedge clk);
            req = 1'b0;
            lat++;
            if (memWrtEn) begin
                wcnt++;
                wd = memDIn;
            end
        end while (!done && lat < 12);
        e = err;
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int          lat;
        int          wc;
        logic [31:0] wd;
        logic        e;
        int          n_done;
        int          n_err;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h8899_AABB;
        ledr = 32'h0;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; signExt = 1'b0;
        addr = 32'h0; wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wen", 32'(memWrtEn), 32'd0);
        check("rst_maddr", memAddr, 32'h0);
        check("rst_mdin", memDIn, 32'h0);
        reset = 1'b0;

        run_op("lb_s", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, lat, wc, wd, e);
        check("lb_s_lat", 32'(lat), 32'd3);
        check("lb_s_rdata", rdata, 32'hFFFF_FFAA);
        check("lb_s_err", 32'(e), 32'd0);

        run_op("lb_z", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, wc, wd, e);
        check("lb_z_rdata", rdata, 32'h0000_00AA);

        run_op("lh_s", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, wc, wd, e);
        check("lh_s_rdata", rdata, 32'hFFFF_8899);

        run_op("lw", 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, lat, wc, wd, e);
        check("lw_lat", 32'(lat), 32'd3);
        check("lw_rdata", rdata, 32'h8899_AABB);

        run_op("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, lat, wc, wd, e);
        check("sh_lat", 32'(lat), 32'd4);
        check("sh_wcnt", 32'(wc), 32'd1);
        check("sh_mdin", wd, 32'h1234_AABB);
        check("sh_rdata_kept", rdata, 32'h8899_AABB);
        run_op("lw2", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, wc, wd, e);
        check("lw2_rdata", rdata, 32'h1234_AABB);

        run_op("sw", 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, lat, wc, wd, e);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_wcnt", 32'(wc), 32'd1);
        check("sw_mdin", wd, 32'hDEAD_BEEF);
        run_op("sb", 1'b1, 2'b00, 1'b0, 32'h203, 32'h0000_00EE, lat, wc, wd, e);
        check("sb_lat", 32'(lat), 32'd4);
        check("sb_mdin", wd, 32'hEEAD_BEEF);
        check("sb_mem", mem[32'h200 >> 2], 32'hEEAD_BEEF);

        run_op("e_lw", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, wc, wd, e);
        check("e_lw_lat", 32'(lat), 32'd1);
        check("e_lw_err", 32'(e), 32'd1);
        check("e_lw_wcnt", 32'(wc), 32'd0);
        check("e_lw_rdata", rdata, 32'h1234_AABB);
        run_op("e_sz", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, wc, wd, e);
        check("e_sz_lat", 32'(lat), 32'd1);
        check("e_sz_err", 32'(e), 32'd1);
        check("e_sz_rdata", rdata, 32'h1234_AABB);
        run_op("e_io", 1'b1, 2'b00, 1'b0, 32'h2000_0004, 32'hFF, lat, wc, wd, e);
        check("e_io_lat", 32'(lat), 32'd1);
        check("e_io_err", 32'(e), 32'd1);
        check("e_io_wcnt", 32'(wc), 32'd0);
        check("e_io_ledr", ledr, 32'h0);

        run_op("io_sw", 1'b1, 2'b10, 1'b0, 32'h2000_0004, 32'h0000_03FF, lat, wc, wd, e);
        check("io_sw_lat", 32'(lat), 32'd2);
        check("io_sw_err", 32'(e), 32'd0);
        check("io_sw_ledr", ledr, 32'h0000_03FF);
        run_op("io_lw", 1'b0, 2'b10, 1'b0, 32'h2000_0008, 32'h0, lat, wc, wd, e);
        check("io_lw_lat", 32'(lat), 32'd3);
        check("io_lw_rdata", rdata, SW_VAL);

        // Second req raised while busy must not produce another completion.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; signExt = 1'b0; addr = 32'h100;
        n_done = 0; n_err = 0;
        @(negedge clk);
        size = 2'b11;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) req = 1'b0;
            if (done) n_done++;
            if (err) n_err++;
            @(negedge clk);
        end
        check("busy_req_dones", 32'(n_done), 32'd1);
        check("busy_req_errs", 32'(n_err), 32'd0);
        check("busy_req_rdata", rdata, 32'h1234_AABB);

        // Reset asserted in the WR cycle of a byte store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; signExt = 1'b0; addr = 32'h100; wdata = 32'h55;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rwr_in_wr", 32'(memWrtEn), 32'd1);
        reset = 1'b1;
        #1;
        check("rwr_wen_gated", 32'(memWrtEn), 32'd0);
        @(negedge clk);
        check("rwr_mem", mem[32'h100 >> 2], 32'h1234_AABB);
        check("rwr_busy", 32'(busy), 32'd0);
        check("rwr_done", 32'(done), 32'd0);
        check("rwr_err", 32'(err), 32'd0);
        check("rwr_rdata", rdata, 32'h0);
        check("rwr_wen", 32'(memWrtEn), 32'd0);
        check("rwr_maddr", memAddr, 32'h0);
        check("rwr_mdin", memDIn, 32'h0);
        reset = 1'b0;

        run_op("post_rst", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat, wc, wd, e);
        check("post_rst_rdata", rdata, 32'h0000_AABB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side controller between the processor datapath and DataMemory, which is the memory/MMIO responder.
- Accepts one load/store request at a time. Drives DataMemory's addr/wrtEn/dIn, captures dOut, and returns aligned data.
- Supports byte, halfword and word accesses, with sign or zero extension.
- Sub-word stores to RAM use read-modify-write. The MMIO region (addr[IO_SEL_BIT]=1) allows word accesses only.

Parameters:
- ADDR_BIT_WIDTH, 32, address width (CPU and memory side).
- DATA_BIT_WIDTH, 32, data width. Lane logic assumes 32; other values are unsupported.
- IO_SEL_BIT, 29, address bit selecting the MMIO region.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1=store, 0=load.
- size  input  2  00=byte, 01=half, 10=word, 11=illegal.
- signExt  input  1  loads: 1=sign-extend, 0=zero-extend.
- addr  input  ADDR_BIT_WIDTH  byte address.
- wdata  input  DATA_BIT_WIDTH  store data, right-aligned.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = request rejected, no memory access made.
- rdata  output  DATA_BIT_WIDTH  load result; held until the next done.
- memWrtEn  output  1  to DataMemory wrtEn.
- memAddr  output  ADDR_BIT_WIDTH  to DataMemory addr; always word-aligned ([1:0]=00).
- memDIn  output  DATA_BIT_WIDTH  to DataMemory dIn.
- memDOut  input  DATA_BIT_WIDTH  from DataMemory dOut; valid the cycle after memAddr is presented.

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, err=0, rdata=0, memWrtEn=0, memAddr=0, memDIn=0.
- memWrtEn is gated by ~reset, so no write is issued in a reset cycle, even when reset arrives mid-operation in WR.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE:
  - req=1 latches we, size, signExt, addr, wdata.
  - Error check. Any of these sends the unit to DONE with err=1: size=11; half with addr[0]=1; word with addr[1:0]!=00; non-word access with addr[IO_SEL_BIT]=1.
  - Otherwise: word store → WR; load or sub-word store → RD.
- RD: memAddr={addr[31:2],00}, memWrtEn=0 → WAIT.
- WAIT: latch memDOut into rbuf.
  - Load → DONE, with rdata loaded from the extracted lane.
  - Store → WR.
- WR: memAddr as in RD, memWrtEn=1 for exactly this cycle, memDIn as follows → DONE.
  - Word store: memDIn=wdata.
  - Sub-word store: memDIn=rbuf with the target lane replaced by the low bits of wdata.
- DONE: done=1 → IDLE. err stays 0 except on the error path.
- Lanes are little-endian:
  - Byte lane = addr[1:0] (lane 0 = bits [7:0]).
  - Half lane = addr[1] (0 = bits [15:0]).
  - Extension fills the upper bits with the lane MSB when signExt=1, else with 0. Word loads ignore signExt.
- Latency, req cycle to done cycle:
  - Error: 1.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
- Interface rules:
  - req while busy=1 is ignored (not queued).
  - A back-to-back req in the cycle after done is accepted.
  - MMIO word loads follow the normal load path. RD is the cycle in which DataMemory latches sw/key; WAIT captures the value.
  - memWrtEn is never asserted outside WR.
  - rdata is not modified by stores or by error completions.

Test Plan:
- Preload word 0x100=0x8899AABB. Load byte, signExt=1, addr 0x101 → done 3 cycles later, rdata=0xFFFFFFAA, err=0. Repeat with signExt=0 → rdata=0x000000AA.
- Load half, signExt=1, addr 0x102 → rdata=0xFFFF8899. Load word 0x100 → rdata=0x8899AABB.
- Store half wdata=0x00001234 to 0x102 (word 0x8899AABB) → one RD, then memWrtEn high exactly 1 cycle with memDIn=0x1234AABB, done at cycle 4. Re-read gives 0x1234AABB.
- Store word 0xDEADBEEF to 0x200 → memWrtEn 1 cycle later, done at cycle 2. Store byte 0xEE to 0x203 → word becomes 0xEEADBEEF.
- Each of these → done+err=1 after 1 cycle, memWrtEn never asserted, rdata unchanged: word load at 0x102; size=11; byte store to 0x20000004. Word store 0x3FF to 0x20000004 → ledr updated, err=0.
- Reset asserted in the WR cycle of a sub-word store → memWrtEn=0 that cycle, the memory word is unchanged, and all outputs hold reset values. req during busy → no extra done pulse.
